// File: rtl/jt7759_prefetch_pkg.sv
// =============================================================================
// jt7759_prefetch_pkg
// Shared definitions for the uPD7759 sample prefetch buffer: the fill FSM
// state encoding and small elaboration-time helpers for sizing and the
// FIFO depth sanity check.
// Revision: 1.0
// =============================================================================
`default_nettype none

package jt7759_prefetch_pkg;

   // Fill FSM states: idle, request issued, waiting for a beat, DRQ gap.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } fill_st_e;

   // Width of a down-counter that must hold max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // FIFO depth must be a power of two between 2 and 16.
   function automatic bit depth_ok(input int d);
      return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/jt7759_prefetch_mem.sv
// =============================================================================
// jt7759_prefetch_mem
// DEPTH x DW register-file FIFO with write pointer, read pointer and fill
// level. A push while full is dropped; a pop while empty is ignored. A clear
// empties the FIFO and takes priority over any simultaneous push or pop.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   clr_i    synchronous clear (pointers and level to zero)
//   push_i   write data_i at the tail
//   data_i   byte to push
//   pop_i    advance the head
//   head_o   current head entry (valid when not empty)
//   level_o  occupancy 0..DEPTH
//   full_o   level == DEPTH
//   empty_o  level == 0
// Revision: 1.0
// =============================================================================
`default_nettype none

module jt7759_prefetch_mem
   import jt7759_prefetch_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic                   push_i,
   input  logic [DW-1:0]          data_i,
   input  logic                   pop_i,
   output logic [DW-1:0]          head_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (level_q == FULL_L);
   assign empty_o = (level_q == '0);
   assign push_ok = push_i & ~full_o & ~clr_i;
   assign pop_ok  = pop_i & ~empty_o & ~clr_i;
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; only entries below the level are ever read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/jt7759_prefetch.sv
// =============================================================================
// jt7759_prefetch
// Sample-data prefetch buffer between the uPD7759 control FSM and the data
// source. Master mode (mdn_i=1) fetches from ROM at an auto-incrementing
// address; slave mode (mdn_i=0) captures host writes paced by drqn_o.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cen_ctl_i           control clock enable, paces the DRQ gap counter
//   mdn_i               1 = master/ROM, 0 = slave/host
//   ctrl_flush_i        empty FIFO, load ROM address from ctrl_addr_i
//   ctrl_cs_i           read request, rising edge = one pop
//   ctrl_busyn_i        1 = decoder idle, FIFO held empty
//   ctrl_addr_i         flush target address
//   ctrl_din_o          popped byte, ctrl_ok_o marks it valid
//   rom_cs_o/rom_addr_o ROM read strobe and address
//   rom_data_i/rom_ok_i ROM data and valid
//   cs_i/wrn_i/din_i    host write port
//   drqn_o              data request, active low
//   level_o             FIFO occupancy 0..DEPTH
// Revision: 1.0
// =============================================================================
`default_nettype none

module jt7759_prefetch
   import jt7759_prefetch_pkg::*;
#(
   parameter int DW      = 8,
   parameter int AW      = 17,
   parameter int DEPTH   = 4,
   parameter int GAP     = 31,
   parameter int LOWATER = DEPTH - 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cen_ctl_i,
   input  logic                   mdn_i,
   input  logic                   ctrl_flush_i,
   input  logic                   ctrl_cs_i,
   input  logic                   ctrl_busyn_i,
   input  logic [AW-1:0]          ctrl_addr_i,
   output logic [DW-1:0]          ctrl_din_o,
   output logic                   ctrl_ok_o,
   output logic                   rom_cs_o,
   output logic [AW-1:0]          rom_addr_o,
   input  logic [DW-1:0]          rom_data_i,
   input  logic                   rom_ok_i,
   input  logic                   cs_i,
   input  logic                   wrn_i,
   input  logic [DW-1:0]          din_i,
   output logic                   drqn_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int GW = cnt_width(GAP);
   localparam logic [LW-1:0] LOWATER_L = LW'(LOWATER);
   localparam logic [GW-1:0] GAP_L     = GW'(GAP);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("jt7759_prefetch: DEPTH must be a power of two in 2..16");
   end

   fill_st_e      state_q;
   logic [GW-1:0] gap_q;
   logic [AW-1:0] addr_q;
   logic          drqn_q;
   logic          drqn_prev_q;
   logic          mdn_q;
   logic          cs_prev_q;
   logic          pend_q;
   logic          ok_q;
   logic [DW-1:0] din_q;

   logic [DW-1:0] head;
   logic          full;
   logic          empty;
   logic          clear;
   logic          abort;
   logic          good_beat;
   logic          push;
   logic          pend_now;
   logic          pop;
   logic [DW-1:0] wdata;

   assign clear = ctrl_flush_i | ctrl_busyn_i;

   // A mode change while a request is outstanding abandons that request.
   assign abort = (mdn_i != mdn_q) && ((state_q == ST_REQ) || (state_q == ST_WAIT));

   // In master mode rom_ok only counts once drqn has been low for a full
   // cycle, so a valid left over from an earlier access is not taken.
   assign good_beat = (state_q == ST_WAIT) &&
                      (mdn_i ? (rom_ok_i & ~drqn_prev_q) : (cs_i & ~wrn_i));
   assign push  = good_beat & ~abort & ~clear;
   assign wdata = mdn_i ? rom_data_i : din_i;

   // The edge that raises ctrl_cs already counts as pending, giving a
   // one-clock pop when data is present.
   assign pend_now = pend_q | (ctrl_cs_i & ~cs_prev_q);
   assign pop      = ctrl_cs_i & pend_now & ~empty & ~clear;

   jt7759_prefetch_mem #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clear),
      .push_i  (push),
      .data_i  (wdata),
      .pop_i   (pop),
      .head_o  (head),
      .level_o (level_o),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         gap_q       <= '0;
         addr_q      <= '0;
         drqn_q      <= 1'b1;
         drqn_prev_q <= 1'b1;
         mdn_q       <= 1'b0;
         cs_prev_q   <= 1'b0;
         pend_q      <= 1'b0;
         ok_q        <= 1'b0;
         din_q       <= '0;
      end else begin
         drqn_prev_q <= drqn_q;
         mdn_q       <= mdn_i;
         cs_prev_q   <= ctrl_cs_i;

         // Pop handshake
         if (!ctrl_cs_i) begin
            pend_q <= 1'b0;
            ok_q   <= 1'b0;
         end else if (pop) begin
            din_q  <= head;
            ok_q   <= 1'b1;
            pend_q <= 1'b0;
         end else begin
            pend_q <= pend_now;
         end

         // Fill FSM
         if (clear) begin
            state_q <= ST_IDLE;
            drqn_q  <= 1'b1;
            gap_q   <= '0;
            if (ctrl_flush_i) addr_q <= ctrl_addr_i;
         end else if (abort) begin
            state_q <= ST_IDLE;
            drqn_q  <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if ((level_o <= LOWATER_L) && !full && (gap_q == '0)) begin
                     state_q <= ST_REQ;
                     drqn_q  <= 1'b0;
                  end
               end
               ST_REQ: state_q <= ST_WAIT;
               ST_WAIT: begin
                  if (good_beat) begin
                     state_q <= ST_GAP;
                     drqn_q  <= 1'b1;
                     gap_q   <= GAP_L;
                     if (mdn_i) addr_q <= addr_q + AW'(1);
                  end
               end
               ST_GAP: begin
                  if (gap_q == '0)    state_q <= ST_IDLE;
                  else if (cen_ctl_i) gap_q   <= gap_q - GW'(1);
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign drqn_o     = drqn_q;
   assign rom_cs_o   = mdn_i & ~drqn_q;
   assign rom_addr_o = addr_q;
   assign ctrl_ok_o  = ok_q;
   assign ctrl_din_o = din_q;

endmodule

`default_nettype wire

// File: tb/tb_jt7759_prefetch.sv
// =============================================================================
// tb_jt7759_prefetch
// Self-checking bench: a queue-based reference model tracks the expected
// FIFO contents, ROM address, request line and pop handshake every cycle.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_jt7759_prefetch;

   localparam int DW = 8, AW = 17, DEPTH = 4, GAP = 3, LOWATER = DEPTH - 1;
   localparam int CEN_PER = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cen_ctl = 1'b0;
   logic          mdn = 1'b1;
   logic          ctrl_flush = 1'b0;
   logic          ctrl_cs = 1'b0;
   logic          ctrl_busyn = 1'b1;
   logic [AW-1:0] ctrl_addr = '0;
   logic [DW-1:0] ctrl_din;
   logic          ctrl_ok;
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;
   logic          rom_ok = 1'b0;
   logic          host_cs = 1'b0;
   logic          host_wrn = 1'b1;
   logic [DW-1:0] host_din = '0;
   logic          drqn;
   logic [2:0]    level;

   jt7759_prefetch #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .GAP(GAP), .LOWATER(LOWATER)
   ) dut (
      .clk_i(clk), .rst_i(rst), .cen_ctl_i(cen_ctl), .mdn_i(mdn),
      .ctrl_flush_i(ctrl_flush), .ctrl_cs_i(ctrl_cs), .ctrl_busyn_i(ctrl_busyn),
      .ctrl_addr_i(ctrl_addr), .ctrl_din_o(ctrl_din), .ctrl_ok_o(ctrl_ok),
      .rom_cs_o(rom_cs), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
      .rom_ok_i(rom_ok), .cs_i(host_cs), .wrn_i(host_wrn), .din_i(host_din),
      .drqn_o(drqn), .level_o(level)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rom_byte(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h3C;
   endfunction

   // ---------------- reference model ----------------
   logic [DW-1:0] q[$];
   int            m_age = 0;     // cycles drqn has been low (0 = high)
   int            m_gap = 0;
   bit            m_ingap = 0;
   logic [AW-1:0] m_addr = '0;
   bit            m_ok = 0;
   logic [DW-1:0] m_din = '0;
   bit            m_pend = 0, m_cs_prev = 0, m_mdn_prev = 0;

   task automatic model_step();
      int lvl;
      bit clear, pend, pop, abort, beat;
      logic [DW-1:0] wdata;
      if (rst) begin
         q.delete(); m_age = 0; m_gap = 0; m_ingap = 0; m_addr = '0;
         m_ok = 0; m_din = '0; m_pend = 0; m_cs_prev = 0; m_mdn_prev = 0;
         return;
      end
      lvl   = q.size();
      clear = ctrl_flush || ctrl_busyn;
      pend  = m_pend || (ctrl_cs && !m_cs_prev);
      pop   = ctrl_cs && pend && (lvl > 0) && !clear;
      abort = (mdn != m_mdn_prev) && (m_age > 0);
      beat  = (m_age >= 2) && (mdn ? rom_ok : (host_cs && !host_wrn));
      wdata = mdn ? rom_data : host_din;

      if (!ctrl_cs) begin m_ok = 0; m_pend = 0; end
      else if (pop) begin m_din = q[0]; m_ok = 1; m_pend = 0; end
      else m_pend = pend;

      if (clear) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (beat && !abort && lvl < DEPTH) q.push_back(wdata);
      end

      if (clear) begin
         m_age = 0; m_gap = 0; m_ingap = 0;
         if (ctrl_flush) m_addr = ctrl_addr;
      end else if (abort) m_age = 0;
      else if (m_age > 0) begin
         if (beat) begin
            m_age = 0; m_gap = GAP; m_ingap = 1;
            if (mdn) m_addr = m_addr + 1'b1;
         end else m_age++;
      end else if (m_ingap) begin
         if (m_gap == 0) m_ingap = 0;
         else if (cen_ctl) m_gap--;
      end else if (lvl <= LOWATER && lvl < DEPTH && m_gap == 0) m_age = 1;

      m_cs_prev  = ctrl_cs;
      m_mdn_prev = mdn;
   endtask

   // ---------------- stimulus helpers ----------------
   bit rom_auto = 1, rom_noise = 0, rom_cs_prev = 0;
   bit host_auto = 0, cen_rand = 0;
   bit track_gap = 0, rise_ok = 0, prev_drqn = 1;
   int rise_cyc = 0, min_hi = 1000;

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("drqn",     32'(drqn),     32'(m_age == 0));
      check("rom_cs",   32'(rom_cs),   32'(mdn && m_age > 0));
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("level",    32'(level),    32'(q.size()));
      check("ctrl_ok",  32'(ctrl_ok),  32'(m_ok));
      check("ctrl_din", 32'(ctrl_din), 32'(m_din));
      cyc++;
      if (track_gap) begin
         if (drqn && !prev_drqn) begin rise_cyc = cyc; rise_ok = 1; end
         if (!drqn && prev_drqn && rise_ok && (cyc - rise_cyc) < min_hi) min_hi = cyc - rise_cyc;
      end
      prev_drqn = drqn;
      cen_ctl = cen_rand ? 1'($urandom_range(0, 1)) : (cyc % CEN_PER == CEN_PER - 1);
      if (rom_auto) begin
         rom_ok   = rom_cs ? (rom_cs_prev || (rom_noise && $urandom_range(0, 3) == 0))
                           : (rom_noise && $urandom_range(0, 3) == 0);
         rom_data = rom_byte(rom_addr);
      end
      rom_cs_prev = rom_cs;
      if (host_auto) begin
         host_cs  = 1'($urandom_range(0, 1));
         host_wrn = !drqn ? !host_cs : ($urandom_range(0, 4) != 0);
         host_din = 8'($urandom);
      end
   endtask

   task automatic wait_drqn_low(input string name);
      int n = 0;
      while (drqn && n < 100) begin tick(); n++; end
      if (drqn) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic host_write(input logic [DW-1:0] b);
      int n = 0;
      wait_drqn_low("host_req");
      host_cs = 1; host_wrn = 0; host_din = b;
      tick();
      while (!drqn && n < 50) begin tick(); n++; end
      if (!drqn) check("host_write_timeout", 0, 1);
      host_cs = 0; host_wrn = 1;
   endtask

   task automatic pop_expect(input string name, input logic [DW-1:0] exp);
      int n = 0;
      ctrl_cs = 1;
      tick();
      while (!ctrl_ok && n < 100) begin tick(); n++; end
      check(name, 32'(ctrl_din), 32'(exp));
      check({name, "_ok"}, 32'(ctrl_ok), 1);
      ctrl_cs = 0;
      tick();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n, lows;

      // Reset
      tick(); tick();
      check("rst_drqn", 32'(drqn), 1);
      check("rst_ok", 32'(ctrl_ok), 0);
      check("rst_din", 32'(ctrl_din), 0);
      check("rst_addr", 32'(rom_addr), 0);
      check("rst_level", 32'(level), 0);
      rst = 0;

      // Master fill across the address wrap, GAP=3 with cen every 4th clk
      mdn = 1; ctrl_busyn = 0; ctrl_flush = 1; ctrl_addr = 17'h1FFFE;
      tick();
      ctrl_flush = 0; track_gap = 1; rise_ok = 0;
      n = 0;
      while (level != 3'd4 && n < 300) begin tick(); n++; end
      track_gap = 0;
      check("fill_level", 32'(level), 4);
      check("fill_addr", 32'(rom_addr), 32'h00002);
      check("gap_min_ok", 32'(min_hi >= GAP * CEN_PER - (CEN_PER - 1)), 1);
      lows = 0;
      for (int i = 0; i < 30; i++) begin tick(); if (!drqn) lows++; end
      check("full_no_req", 32'(lows), 0);
      pop_expect("pop_1FFFE", 8'hC2);
      pop_expect("pop_1FFFF", 8'hC3);
      pop_expect("pop_00000", 8'h3C);
      pop_expect("pop_00001", 8'h3D);

      // Slave mode host writes
      mdn = 0; ctrl_flush = 1;
      tick();
      ctrl_flush = 0;
      host_write(8'hA5); host_write(8'h5A); host_write(8'hC3);
      pop_expect("slave_A5", 8'hA5);
      pop_expect("slave_5A", 8'h5A);
      pop_expect("slave_C3", 8'hC3);
      ctrl_cs = 1;
      for (int i = 0; i < 5; i++) tick();
      check("empty_pend_ok", 32'(ctrl_ok), 0);
      host_write(8'h77);
      check("pend_before", 32'(ctrl_ok), 0);
      tick();
      check("pend_ok", 32'(ctrl_ok), 1);
      check("pend_din", 32'(ctrl_din), 32'h77);
      ctrl_cs = 0;
      tick();

      // Push and pop on the same edge at level 2
      host_write(8'h11); host_write(8'h22);
      wait_drqn_low("pp_req");
      tick();
      ctrl_cs = 1; host_cs = 1; host_wrn = 0; host_din = 8'h33;
      tick();
      check("pp_level", 32'(level), 2);
      check("pp_din", 32'(ctrl_din), 32'h11);
      host_cs = 0; host_wrn = 1; ctrl_cs = 0;
      tick();
      pop_expect("pp_22", 8'h22);
      pop_expect("pp_33", 8'h33);

      // Flush during WAIT with rom_ok in the same cycle
      mdn = 1;
      n = 0;
      while (level < 3'd2 && n < 200) begin tick(); n++; end
      wait_drqn_low("fl_req");
      rom_auto = 0; rom_ok = 0;
      tick();
      ctrl_flush = 1; ctrl_addr = 17'h0ABCD; rom_ok = 1; rom_data = 8'hEE;
      tick();
      check("fl_level", 32'(level), 0);
      check("fl_addr", 32'(rom_addr), 32'h0ABCD);
      check("fl_drqn", 32'(drqn), 1);
      ctrl_flush = 0; rom_ok = 0; rom_auto = 1;
      tick();

      // Randomized traffic
      rom_noise = 1; host_auto = 1; cen_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) mdn = ~mdn;
         ctrl_flush = ($urandom_range(0, 79) == 0);
         ctrl_addr  = AW'($urandom);
         ctrl_busyn = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 2) == 0) ctrl_cs = ~ctrl_cs;
         tick();
      end
      rom_noise = 0; host_auto = 0; cen_rand = 0;
      host_cs = 0; host_wrn = 1; ctrl_flush = 0; ctrl_busyn = 0;

      // Reset mid-transfer
      mdn = 1; ctrl_cs = 1;
      wait_drqn_low("rst_req");
      rst = 1;
      tick();
      check("mid_rst_drqn", 32'(drqn), 1);
      check("mid_rst_level", 32'(level), 0);
      check("mid_rst_addr", 32'(rom_addr), 0);
      check("mid_rst_ok", 32'(ctrl_ok), 0);
      check("mid_rst_din", 32'(ctrl_din), 0);
      rst = 0; ctrl_cs = 0;
      for (int i = 0; i < 20; i++) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
